mlp_layer_sequencer: RTL

//  Descriptor-driven controller for an N-layer MLP inference pass on shared MM/ReLU/argmax engines.

---
 rtl/mlp_layer_sequencer_if.sv | 35 +++
 rtl/mlp_layer_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Engine-side bus of the MLP layer sequencer: MM, ReLU and argmax start/done handshakes
// plus the operand/bank selects the engines consume while running.
interface mlp_layer_sequencer_if #(
  parameter int unsigned DIM_W = 10
);
  logic             mm_start;
  logic [DIM_W-1:0] mm_k;
  logic [DIM_W-1:0] mm_n;
  logic [1:0]       mm_src_sel;
  logic [1:0]       mm_dst_sel;
  logic             mm_done;

  logic             relu_start;
  logic [DIM_W-1:0] relu_d;
  logic             relu_done;

  logic             argmax_start;
  logic [DIM_W-1:0] argmax_size;
  logic             argmax_done;
  logic [3:0]       argmax_index;

  modport master (
    output mm_start, mm_k, mm_n, mm_src_sel, mm_dst_sel,
    output relu_start, relu_d,
    output argmax_start, argmax_size,
    input  mm_done, relu_done, argmax_done, argmax_index
  );

  modport slave (
    input  mm_start, mm_k, mm_n, mm_src_sel, mm_dst_sel,
    input  relu_start, relu_d,
    input  argmax_start, argmax_size,
    output mm_done, relu_done, argmax_done, argmax_index
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Descriptor-driven sequencer for an N-layer MLP pass: fetches per-layer k/n/ReLU, drives the
// shared MM/ReLU/argmax engines with ping-pong banks, and reports result, errors and timeouts.
module mlp_layer_sequencer #(
  parameter int unsigned MAX_LAYERS  = 8,
  parameter int unsigned LIDX_W      = 3,
  parameter int unsigned DIM_W       = 10,
  parameter int unsigned TIMEOUT_W   = 20,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LIDX_W:0]       num_layers,
  output logic [LIDX_W-1:0]     desc_idx,
  input  logic [DIM_W-1:0]      desc_k,
  input  logic [DIM_W-1:0]      desc_n,
  input  logic                  desc_relu,
  mlp_layer_sequencer_if.master eng,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            result_index,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_MM     = 3'd2,
    ST_RELU   = 3'd3,
    ST_ARGMAX = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LAYERS  = 2'd1,
    ERR_DIM     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [1:0]           SEL_IMG    = 2'd0;
  localparam logic [1:0]           SEL_A      = 2'd1;
  localparam logic [1:0]           SEL_B      = 2'd2;
  localparam logic [LIDX_W:0]      MAX_NL     = (LIDX_W+1)'(MAX_LAYERS);
  localparam logic [TIMEOUT_W-1:0] WDOG_LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [LIDX_W-1:0]    layer_q, layer_d;
  logic [LIDX_W:0]      nlayers_q, nlayers_d;
  logic [DIM_W-1:0]     k_q, k_d;
  logic [DIM_W-1:0]     n_q, n_d;
  logic                 relu_en_q, relu_en_d;
  logic                 entry_q, entry_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [3:0]           result_q, result_d;
  logic                 error_q, error_d;
  err_e                 err_code_q, err_code_d;

  logic                 last_layer;
  logic                 wdog_hit;
  logic                 counting;
  logic                 raise;
  err_e                 raise_code;
  logic [1:0]           src_bank;
  logic [1:0]           dst_bank;

  assign last_layer = ({1'b0, layer_q} == (nlayers_q - (LIDX_W+1)'(1)));
  assign wdog_hit   = (wdog_q == WDOG_LIMIT);
  assign counting   = (state_q == ST_MM) || (state_q == ST_RELU) || (state_q == ST_ARGMAX);

  // Even layers write bank A, odd layers bank B; each layer reads what the previous one wrote.
  assign dst_bank = layer_q[0] ? SEL_B : SEL_A;
  assign src_bank = (layer_q == '0) ? SEL_IMG : (layer_q[0] ? SEL_A : SEL_B);

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    nlayers_d  = nlayers_q;
    k_d        = k_q;
    n_d        = n_q;
    relu_en_d  = relu_en_q;
    result_d   = result_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    raise      = 1'b0;
    raise_code = ERR_NONE;

    // Abort wins over everything else, including an engine done in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            nlayers_d  = num_layers;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            result_d   = '0;
            layer_d    = '0;
            if ((num_layers == '0) || (num_layers > MAX_NL)) begin
              raise      = 1'b1;
              raise_code = ERR_LAYERS;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          k_d       = desc_k;
          n_d       = desc_n;
          relu_en_d = desc_relu;
          if ((desc_k == '0) || (desc_n == '0)) begin
            raise      = 1'b1;
            raise_code = ERR_DIM;
          end else begin
            state_d = ST_MM;
          end
        end
        ST_MM: begin
          if (eng.mm_done) begin
            if (relu_en_q) begin
              state_d = ST_RELU;
            end else if (last_layer) begin
              state_d = ST_ARGMAX;
            end else begin
              layer_d = layer_q + LIDX_W'(1);
              state_d = ST_FETCH;
            end
          end else if (wdog_hit) begin
            raise      = 1'b1;
            raise_code = ERR_TIMEOUT;
          end
        end
        ST_RELU: begin
          if (eng.relu_done) begin
            if (last_layer) begin
              state_d = ST_ARGMAX;
            end else begin
              layer_d = layer_q + LIDX_W'(1);
              state_d = ST_FETCH;
            end
          end else if (wdog_hit) begin
            raise      = 1'b1;
            raise_code = ERR_TIMEOUT;
          end
        end
        ST_ARGMAX: begin
          if (eng.argmax_done) begin
            result_d = eng.argmax_index;
            state_d  = ST_DONE;
          end else if (wdog_hit) begin
            raise      = 1'b1;
            raise_code = ERR_TIMEOUT;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_ERROR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      if (raise) begin
        state_d    = ST_ERROR;
        error_d    = 1'b1;
        err_code_d = raise_code;
      end
    end

    entry_d = (state_d != state_q);
    if ((state_d != state_q) || !counting) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      layer_q    <= '0;
      nlayers_q  <= '0;
      k_q        <= '0;
      n_q        <= '0;
      relu_en_q  <= 1'b0;
      entry_q    <= 1'b0;
      wdog_q     <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      nlayers_q  <= nlayers_d;
      k_q        <= k_d;
      n_q        <= n_d;
      relu_en_q  <= relu_en_d;
      entry_q    <= entry_d;
      wdog_q     <= wdog_d;
      result_q   <= result_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Start pulses fire only on the first cycle of their state and never alongside an abort.
  assign eng.mm_start     = (state_q == ST_MM)     && entry_q && !abort;
  assign eng.relu_start   = (state_q == ST_RELU)   && entry_q && !abort;
  assign eng.argmax_start = (state_q == ST_ARGMAX) && entry_q && !abort;

  assign eng.mm_k        = k_q;
  assign eng.mm_n        = n_q;
  assign eng.mm_src_sel  = (state_q == ST_MM) ? src_bank : SEL_IMG;
  assign eng.mm_dst_sel  = counting ? dst_bank : SEL_IMG;
  assign eng.relu_d      = n_q;
  assign eng.argmax_size = n_q;

  assign desc_idx     = layer_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign result_index = result_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign state        = state_q;

endmodule
